// File: rtl/free_slot_allocator.sv
// rtl/free_slot_allocator.sv - registered free-slot allocator with valid/take offer and release checking
// Optional round-robin search order: define SLOT_ALLOCATOR_ROUND_ROBIN_EN.
module free_slot_allocator #(
    parameter int NUM_SLOTS   = 32,
    parameter int INDEX_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   alloc_valid,
    output logic [INDEX_WIDTH-1:0] alloc_index,
    input  logic                   alloc_take,
    input  logic                   free_valid,
    input  logic [INDEX_WIDTH-1:0] free_index,
    output logic [NUM_SLOTS-1:0]   occupancy,
    output logic [INDEX_WIDTH:0]   free_count,
    output logic                   full,
    output logic                   err
);

    logic                   take_ok;
    logic                   free_ok;
    logic                   err_next;
    logic [NUM_SLOTS-1:0]   next_occ;
    logic [INDEX_WIDTH:0]   used_next;
    logic                   lo_found;
    logic [INDEX_WIDTH-1:0] lo_index;
    logic                   hi_found;
    logic [INDEX_WIDTH-1:0] hi_index;
    logic                   any_free;
    logic [INDEX_WIDTH-1:0] search_index;
    logic [INDEX_WIDTH-1:0] search_start;

`ifdef SLOT_ALLOCATOR_ROUND_ROBIN_EN
    logic [INDEX_WIDTH-1:0] search_ptr;

    // The pointer update from this cycle's take already steers this cycle's search.
    always_comb begin
        search_start = search_ptr;
        if (take_ok) begin
            if (alloc_index == INDEX_WIDTH'(NUM_SLOTS - 1))
                search_start = '0;
            else
                search_start = alloc_index + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            search_ptr <= '0;
        else
            search_ptr <= search_start;
    end
`else
    assign search_start = '0;
`endif

    always_comb begin
        take_ok = alloc_take && alloc_valid;
        free_ok = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (free_valid && free_index == INDEX_WIDTH'(i) && occupancy[i])
                free_ok = 1'b1;
        end
        err_next = (alloc_take && !alloc_valid) || (free_valid && !free_ok);

        // A same-index take and free never both apply: the offered slot is free, so the free is illegal.
        next_occ = occupancy;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (take_ok && alloc_index == INDEX_WIDTH'(i))
                next_occ[i] = 1'b1;
            if (free_ok && free_index == INDEX_WIDTH'(i))
                next_occ[i] = 1'b0;
        end

        used_next = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            used_next = used_next + (INDEX_WIDTH+1)'(next_occ[i]);
    end

    // Two-pass search: first free at or above the start point, else first free overall (wrap).
    always_comb begin
        lo_found = 1'b0;
        lo_index = '0;
        hi_found = 1'b0;
        hi_index = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!next_occ[i]) begin
                lo_found = 1'b1;
                lo_index = INDEX_WIDTH'(i);
                if (INDEX_WIDTH'(i) >= search_start) begin
                    hi_found = 1'b1;
                    hi_index = INDEX_WIDTH'(i);
                end
            end
        end
        any_free     = lo_found;
        search_index = hi_found ? hi_index : lo_index;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy   <= '0;
            alloc_valid <= 1'b0;
            alloc_index <= '0;
            free_count  <= (INDEX_WIDTH+1)'(NUM_SLOTS);
            err         <= 1'b0;
        end else begin
            occupancy   <= next_occ;
            alloc_valid <= any_free;
            if (any_free)
                alloc_index <= search_index;
            free_count  <= (INDEX_WIDTH+1)'(NUM_SLOTS) - used_next;
            err         <= err_next;
        end
    end

    assign full = (free_count == '0);

endmodule

// File: tb/tb_free_slot_allocator.sv
// tb/tb_free_slot_allocator.sv - table-driven bench for free_slot_allocator, NUM_SLOTS=8
module tb_free_slot_allocator;

    logic       clk = 1'b0;
    logic       reset;
    logic       alloc_valid;
    logic [3:0] alloc_index;
    logic       alloc_take;
    logic       free_valid;
    logic [3:0] free_index;
    logic [7:0] occupancy;
    logic [4:0] free_count;
    logic       full;
    logic       err;

    int checks = 0;
    int errors = 0;
    int vec_no = 0;

    always #5 clk = ~clk;

    free_slot_allocator #(.NUM_SLOTS(8), .INDEX_WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_index(alloc_index), .alloc_take(alloc_take),
        .free_valid(free_valid), .free_index(free_index),
        .occupancy(occupancy), .free_count(free_count), .full(full), .err(err)
    );

    typedef struct {
        logic       rst;
        logic       take;
        logic       fv;
        logic [3:0] fi;
        logic       ev;
        logic [3:0] ei;
        logic [4:0] ec;
        logic [7:0] eo;
        logic       ee;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic take, input logic fv, input logic [3:0] fi,
                       input logic ev, input logic [3:0] ei, input logic [4:0] ec,
                       input logic [7:0] eo, input logic ee);
        vec_t v;
        v = '{rst, take, fv, fi, ev, ei, ec, eo, ee};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s step %0d actual %0h required %0h", name, vec_no, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic take, input logic fv, input logic [3:0] fi);
        reset      = rst;
        alloc_take = take;
        free_valid = fv;
        free_index = fi;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        alloc_take = 1'b0;
        free_valid = 1'b0;
        free_index = '0;
        vec_no++;
    endtask

    task automatic chk_state(input logic ev, input logic [3:0] ei, input logic [4:0] ec,
                             input logic [7:0] eo, input logic ee);
        chk("alloc_valid", int'(alloc_valid), int'(ev));
        chk("alloc_index", int'(alloc_index), int'(ei));
        chk("free_count",  int'(free_count),  int'(ec));
        chk("full",        int'(full),        int'(ec == 5'd0));
        chk("occupancy",   int'(occupancy),   int'(eo));
        chk("err",         int'(err),         int'(ee));
    endtask

    initial begin
        reset = 1'b1; alloc_take = 1'b0; free_valid = 1'b0; free_index = '0;

        //  rst take fv fi     ev  ei     ec     eo     ee
        add(1, 0, 0, 4'd0,  0, 4'd0, 5'd8, 8'h00, 0);
        add(0, 0, 0, 4'd0,  1, 4'd0, 5'd8, 8'h00, 0);
        add(0, 1, 0, 4'd0,  1, 4'd1, 5'd7, 8'h01, 0);
        add(0, 1, 0, 4'd0,  1, 4'd2, 5'd6, 8'h03, 0);
        add(0, 1, 0, 4'd0,  1, 4'd3, 5'd5, 8'h07, 0);
        add(0, 1, 0, 4'd0,  1, 4'd4, 5'd4, 8'h0F, 0);
        add(0, 1, 0, 4'd0,  1, 4'd5, 5'd3, 8'h1F, 0);
        add(0, 1, 0, 4'd0,  1, 4'd6, 5'd2, 8'h3F, 0);
        add(0, 1, 0, 4'd0,  1, 4'd7, 5'd1, 8'h7F, 0);
        add(0, 1, 0, 4'd0,  0, 4'd7, 5'd0, 8'hFF, 0);
        add(0, 0, 1, 4'd5,  1, 4'd5, 5'd1, 8'hDF, 0);
        add(0, 0, 1, 4'd5,  1, 4'd5, 5'd1, 8'hDF, 1);
        add(0, 0, 0, 4'd0,  1, 4'd5, 5'd1, 8'hDF, 0);
        add(0, 1, 1, 4'd2,  1, 4'd2, 5'd1, 8'hFB, 0);
        add(0, 1, 1, 4'd6,  1, 4'd6, 5'd1, 8'hBF, 0);
        add(0, 0, 1, 4'd9,  1, 4'd6, 5'd1, 8'hBF, 1);
        add(0, 1, 0, 4'd0,  0, 4'd6, 5'd0, 8'hFF, 0);
        add(0, 1, 0, 4'd0,  0, 4'd6, 5'd0, 8'hFF, 1);
        add(0, 0, 1, 4'd3,  1, 4'd3, 5'd1, 8'hF7, 0);
        add(0, 1, 1, 4'd0,  1, 4'd0, 5'd1, 8'hFE, 0);
        add(0, 1, 1, 4'd0,  0, 4'd0, 5'd0, 8'hFF, 1);
        add(0, 0, 1, 4'd1,  1, 4'd1, 5'd1, 8'hFD, 0);
        add(1, 1, 1, 4'd0,  0, 4'd0, 5'd8, 8'h00, 0);
        add(0, 0, 0, 4'd0,  1, 4'd0, 5'd8, 8'h00, 0);
        add(0, 1, 0, 4'd0,  1, 4'd1, 5'd7, 8'h01, 0);
        add(0, 1, 0, 4'd0,  1, 4'd2, 5'd6, 8'h03, 0);

        @(posedge clk);
        #1;
        foreach (vecs[n]) begin
            step(vecs[n].rst, vecs[n].take, vecs[n].fv, vecs[n].fi);
            chk_state(vecs[n].ev, vecs[n].ei, vecs[n].ec, vecs[n].eo, vecs[n].ee);
        end

        // Slots 0 and 1 are taken; release 0 and observe where the next offer goes.
        step(0, 0, 1, 4'd0);
`ifdef SLOT_ALLOCATOR_ROUND_ROBIN_EN
        chk_state(1, 4'd2, 5'd7, 8'h02, 0);
        for (int k = 2; k <= 7; k++) begin
            step(0, 1, 0, 4'd0);
            chk("rr_index", int'(alloc_index), (k == 7) ? 0 : k + 1);
        end
        chk_state(1, 4'd0, 5'd1, 8'hFE, 0);
`else
        chk_state(1, 4'd0, 5'd7, 8'h02, 0);
        step(0, 1, 0, 4'd0);
        chk_state(1, 4'd2, 5'd6, 8'h03, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/free_slot_allocator.md
# free_slot_allocator

Registered free-slot allocator for the reference switch output-queue and packet-buffer managers. Tracks occupancy of NUM_SLOTS buffer slots and presents the next free slot index every cycle through a valid/take handshake. Also accepts slot releases, counts free slots and flags illegal releases. Replaces ad-hoc combinational first-zero searches with a pipelined, stateful allocator.

## Interface
Parameters:
- NUM_SLOTS, 32, number of tracked slots; must satisfy 1 ≤ NUM_SLOTS ≤ 2**INDEX_WIDTH
- INDEX_WIDTH, 5, width of slot index ports

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- alloc_valid  out  1  alloc_index holds a free slot
- alloc_index  out  INDEX_WIDTH  offered free slot index
- alloc_take  in  1  consumer claims alloc_index this cycle
- free_valid  in  1  release request
- free_index  in  INDEX_WIDTH  slot to release
- occupancy  out  NUM_SLOTS  bit i = 1 when slot i allocated
- free_count  out  INDEX_WIDTH+1  number of zero bits in occupancy
- full  out  1  free_count == 0
- err  out  1  one-cycle pulse on an illegal request

## Operation
- State: occupancy register; registered alloc_valid/alloc_index; free_count; err; search pointer (round-robin mode only).
- Each cycle, build next_occ from occupancy:
  - set bit alloc_index if alloc_take && alloc_valid;
  - then clear bit free_index if the free is legal.
- Legal free: free_valid && free_index < NUM_SLOTS && occupancy[free_index] == 1.
- Illegal free: any other free_valid. It is ignored and err pulses next cycle.
- alloc_take with alloc_valid == 0 is ignored and err pulses next cycle.
- Simultaneous take and free of the same index: the slot was free, so the free is illegal. The take wins, the free is ignored and err pulses.
- Simultaneous take and free of different indices: both applied in the same cycle.
- Next offer is a search over next_occ:
  - alloc_valid_next = 1 if any zero bit exists below NUM_SLOTS; otherwise 0, and alloc_index holds its previous value.
  - alloc_index_next = first zero bit found per the search order (see Configuration).
- free_count_next = NUM_SLOTS − popcount(next_occ).
- full is derived combinationally from the free_count register.
- Reset (any cycle, including mid-operation):
  - occupancy = 0, alloc_valid = 0, alloc_index = 0, free_count = NUM_SLOTS, err = 0, search pointer = 0;
  - inputs sampled on reset cycles are discarded.

## Timing
- All outputs registered except full, which is a decode of the free_count register.
- Take → occupancy bit set, new alloc_index and free_count visible: 1 cycle.
- Legal free → slot visible in occupancy, free_count and (if selected) alloc_index: 1 cycle.
- Illegal request → err high for exactly 1 cycle, on the cycle after the request.
- Back-to-back takes sustained every cycle while free slots remain. Each cycle offers a distinct index.
- First cycle after reset deasserts: alloc_valid = 1, alloc_index = 0.
- Full boundary: with one free slot, a take drives alloc_valid = 0 and full = 1 next cycle. A free in that same cycle instead keeps alloc_valid = 1, offering the freed slot.

## Configuration
- SLOT_ALLOCATOR_ROUND_ROBIN_EN defined:
  - search order starts at the search pointer and wraps modulo NUM_SLOTS;
  - on each accepted take, pointer ← (taken index + 1) mod NUM_SLOTS, applied for the same cycle's search;
  - spreads slot reuse across the buffer.
- Undefined:
  - search is always lowest-index-first from 0;
  - no pointer register.

## Test plan
- Reset then idle, NUM_SLOTS=8:
  - alloc_valid=1, alloc_index=0, free_count=8, full=0, occupancy=0x00.
- Take on 8 consecutive cycles (lowest-first):
  - indices 0..7 offered in order; after the 8th take, alloc_valid=0, full=1, free_count=0, occupancy=0xFF.
- From full, free index 5:
  - next cycle alloc_valid=1, alloc_index=5, free_count=1, occupancy=0xDF.
  - Freeing 5 again → err pulse, occupancy unchanged.
- Same cycle: take index 2 (offered) and free index 6 (occupied):
  - next cycle occupancy has bit 2 set and bit 6 cleared; free_count unchanged; err=0.
- free_index=9 with NUM_SLOTS=8, and take while alloc_valid=0:
  - each produces a 1-cycle err pulse; state unchanged.
- With SLOT_ALLOCATOR_ROUND_ROBIN_EN: take 0, 1, then free 0:
  - next offer is 2, not 0.
  - After slots 2..7 are taken, the pointer wraps and index 0 is offered.
- Assert reset mid-burst:
  - all outputs return to reset values the next cycle; prior occupancy is lost.
